// File: rtl/sp_ram_init_ctrl.sv
// Single-port RAM initiator: clears every word to INIT_VALUE after reset or on
// request, then forwards core-style req/gnt/rvalid accesses to the RAM port.
module sp_ram_init_ctrl #(
  parameter int          RAM_SIZE   = 32768,
  parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  init_start_i,
  output logic                  init_busy_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_bypass_en_o
);

  localparam int NUM_WORDS = RAM_SIZE / 4;
  localparam int WIDX      = ADDR_WIDTH - 2;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_e;

  state_e            state_q, state_d;
  logic [WIDX-1:0]   cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              grant;

  // The two byte-offset bits of the request address never reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];

  always_comb begin
    grant    = (state_q == READY) & data_req_i & ~init_start_i;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = grant;
    case (state_q)
      IDLE: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = READY;
        end
      end
      READY: begin
        if (init_start_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    init_busy_o = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_wdata_o = '0;
    ram_addr_o  = '0;
    if (state_q == INIT) begin
      init_busy_o = 1'b1;
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_be_o    = 4'hF;
      ram_wdata_o = INIT_VALUE[DATA_WIDTH-1:0];
      ram_addr_o  = {cnt_q, 2'b00};
    end else if (grant) begin
      ram_en_o    = 1'b1;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_wdata_o = data_wdata_i;
      ram_addr_o  = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  assign data_gnt_o      = grant;
  assign data_rvalid_o   = rvalid_q;
  // Read data is only forwarded alongside a response so idle outputs stay 0.
  assign data_rdata_o    = rvalid_q ? ram_rdata_i : '0;
  assign ram_bypass_en_o = 1'b0;

endmodule

// File: tb/tb_sp_ram_init_ctrl.sv
// Bench for sp_ram_init_ctrl with a 16-word behavioural RAM and a
// transaction-level memory model feeding a response scoreboard.
module tb_sp_ram_init_ctrl;

  localparam int RS = 64;
  localparam int AW = 6;
  localparam int NW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          init_start_i = 1'b0;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = 4'h0;
  logic [31:0]   data_wdata_i = '0;
  logic          init_busy_o, data_gnt_o, data_rvalid_o;
  logic [31:0]   data_rdata_o, ram_wdata_o, ram_rdata_i;
  logic          ram_en_o, ram_we_o, ram_bypass_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_be_o;

  sp_ram_init_ctrl #(.RAM_SIZE(RS), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .INIT_VALUE(32'h0)) dut (
    .clk(clk), .rst_i(rst_i), .init_start_i(init_start_i), .init_busy_o(init_busy_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .ram_bypass_en_o(ram_bypass_en_o)
  );

  // Behavioural single-port RAM, one-cycle read latency, starts with garbage.
  logic [31:0] ram_mem [NW];
  logic [31:0] ram_rdata_q;
  assign ram_rdata_i = ram_rdata_q;
  initial begin
    for (int i = 0; i < NW; i++) ram_mem[i] = $urandom;
    ram_rdata_q = $urandom;
  end
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o)
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_q <= ram_mem[ram_addr_o[AW-1:2]];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] mask);
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h required %h (mask %h)", name, cyc, act & mask, exp & mask, mask);
    end
  endtask

  typedef struct {
    bit          is_read;
    logic [3:0]  widx;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Reference model: phase 0 = held in/just out of reset, 1 = clearing, 2 = ready.
  int          phase = 0;
  int          busy_left = 0;
  logic [31:0] ref_mem [NW];

  always @(negedge clk) begin
    logic [63:0] act, exp, msk;
    bit g;
    exp_t e;
    act = {17'h0, ram_en_o, ram_we_o, ram_be_o, ram_wdata_o, ram_addr_o,
           data_gnt_o, init_busy_o, ram_bypass_en_o};
    g = 1'b0;
    msk = {64{1'b1}};
    if (phase == 0) begin
      exp = '0;
      check("reset_outputs", act, exp, msk);
      check("reset_resp", {31'h0, data_rvalid_o, data_rdata_o}, 64'h0, msk);
    end else if (phase == 1) begin
      exp = {17'h0, 1'b1, 1'b1, 4'hF, 32'h0, 6'((NW - busy_left) * 4), 1'b0, 1'b1, 1'b0};
      check("clear_port", act, exp, msk);
    end else begin
      g = data_req_i & ~init_start_i;
      if (g) begin
        exp = {17'h0, 1'b1, data_we_i, data_be_i, data_wdata_i,
               data_addr_i[AW-1:2], 2'b00, 1'b1, 1'b0, 1'b0};
      end else begin
        exp = '0;
        msk = {17'h0, 1'b1, 1'b1, 4'h0, 32'h0, 6'h0, 1'b1, 1'b1, 1'b1};
      end
      check("ready_port", act, exp, msk);
    end

    if (g && !rst_i) begin
      e.widx = data_addr_i[AW-1:2];
      e.due = cyc + 1;
      e.is_read = !data_we_i;
      if (data_we_i) begin
        for (int b = 0; b < 4; b++)
          if (data_be_i[b]) ref_mem[e.widx][8*b +: 8] = data_wdata_i[8*b +: 8];
        e.data = data_wdata_i;
      end else begin
        e.data = ref_mem[e.widx];
      end
      sb.push_back(e);
    end

    if (rst_i) begin
      phase = 0;
    end else if (phase == 0 || (phase == 2 && init_start_i)) begin
      phase = 1;
      busy_left = NW;
      for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    end else if (phase == 1) begin
      busy_left--;
      if (busy_left == 0) phase = 2;
    end
  end

  // Response monitor: every accepted access must answer exactly one cycle later.
  always @(negedge clk) begin
    bit exp_rv;
    exp_t e;
    exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
    check("rvalid", {63'h0, data_rvalid_o}, {63'h0, exp_rv}, 64'h1);
    if (exp_rv) begin
      e = sb.pop_front();
      if (e.is_read && data_rvalid_o)
        check("rdata", {32'h0, data_rdata_o}, {32'h0, e.data}, 64'hFFFF_FFFF);
      $display("txn cyc=%0d %s word=%0d data=%h", cyc, e.is_read ? "RD" : "WR", e.widx, e.data);
    end
  end

  task automatic drive(input bit req, input logic [AW-1:0] a, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, input bit st, input bit rs);
    data_req_i = req; data_addr_i = a; data_we_i = we; data_be_i = be;
    data_wdata_i = wd; init_start_i = st; rst_i = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Holds the request until granted, bounded so a stuck grant cannot hang the run.
  task automatic access(input logic [AW-1:0] a, input bit we, input logic [3:0] be,
                        input logic [31:0] wd);
    bit g;
    g = 1'b0;
    for (int n = 0; n < 64 && !g; n++) begin
      data_req_i = 1'b1; data_addr_i = a; data_we_i = we; data_be_i = be;
      data_wdata_i = wd; init_start_i = 1'b0; rst_i = 1'b0;
      @(negedge clk);
      g = data_gnt_o;
      @(posedge clk);
      #1;
    end
    check("grant_within_bound", {63'h0, g}, 64'h1, 64'h1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    idle(3);
    // Request plus re-clear pulse during the clear: both must be ignored.
    drive(1'b1, 6'h00, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    access(6'h00, 1'b0, 4'hF, 32'h0);
    for (int i = 1; i < NW; i++) access(6'(i * 4), 1'b0, 4'hF, 32'h0);
    idle(2);

    access(6'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    access(6'h10, 1'b1, 4'b0001, 32'h000000AA);
    access(6'h10, 1'b0, 4'hF, 32'h0);
    idle(2);

    for (int i = 0; i < 4; i++) access(6'(i * 4), 1'b1, 4'hF, 32'(i + 1));
    for (int i = 0; i < 4; i++) access(6'(i * 4), 1'b0, 4'hF, 32'h0);
    idle(2);

    access(6'h3C, 1'b1, 4'hF, 32'h12345678);
    drive(1'b1, 6'h3C, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    access(6'h3C, 1'b0, 4'hF, 32'h0);
    idle(2);

    drive(1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle(6);
    drive(1'b0, '0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    access(6'h04, 1'b0, 4'hF, 32'h0);

    // Reset arriving with a grant: the response must never appear.
    access(6'h08, 1'b1, 4'hF, 32'hCAFE0001);
    drive(1'b1, 6'h08, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
    access(6'h08, 1'b0, 4'hF, 32'h0);

    for (int i = 0; i < 500; i++)
      drive(($urandom % 4) != 0, 6'($urandom), 1'($urandom), 4'($urandom), $urandom,
            ($urandom % 60) == 0, ($urandom % 250) == 0);
    idle(20);
    access(6'h3C, 1'b0, 4'hF, 32'h0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
